// File: rtl/prefetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_pkg
// Purpose  : Constants and FSM state encoding shared by the next-line
//            prefetcher and the prefetch issuer.
// Revision : 1.0 - initial release
// ============================================================================
package prefetch_pkg;

    localparam int ADDR_W          = 32;
    localparam int BLOCK_SIZE_BYTE = 16;
    localparam int QUEUE_DEPTH     = 4;
    localparam int BEAT_BYTES      = 4;
    localparam int OFS             = $clog2(BLOCK_SIZE_BYTE);
    localparam int BLK_W           = ADDR_W - OFS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_FILL = 2'd3
    } issue_state_e;

    // Counter width that never collapses to zero bits (a one-beat block
    // still needs a legal counter).
    function automatic int cnt_width(input int count);
        return (count <= 1) ? 1 : $clog2(count);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pf_req_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pf_req_fifo
// Purpose  : Pending prefetch-request queue. Synchronous FIFO with per-entry
//            valid bits and a combinational "is this address queued" probe.
// Revision : 1.0 - initial release
// ============================================================================
module pf_req_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    input  logic [WIDTH-1:0] match_addr,
    output logic             contains
);
    import prefetch_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [DEPTH-1:0] w_hit;
    logic [PTR_W-1:0] w_wr_idx;
    logic [PTR_W-1:0] w_rd_idx;
    logic             w_push;
    logic             w_pop;

    assign w_wr_idx = wr_ptr_q[PTR_W-1:0];
    assign w_rd_idx = rd_ptr_q[PTR_W-1:0];
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) && (w_wr_idx == w_rd_idx);
    assign w_push   = push && !full;
    assign w_pop    = pop && !empty;
    assign pop_data = mem_q[w_rd_idx];

    // One comparator per slot; only live entries may report a hit.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        assign w_hit[i] = vld_q[i] && (mem_q[i] == match_addr);
    end
    assign contains = |w_hit;

    // Next-state for pointers, storage and valid bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        vld_d    = vld_q;
        mem_d    = mem_q;
        if (w_push) begin
            mem_d[w_wr_idx] = push_data;
            vld_d[w_wr_idx] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            vld_d[w_rd_idx] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
    end

    // Control state is reset; payload storage is qualified by the valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            vld_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            vld_q    <= vld_d;
        end
    end

    // Payload storage update.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/prefetch_issuer.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_issuer
// Purpose  : Queues prefetch block addresses, drops duplicates, issues one
//            block read at a time to memory, assembles the response beats
//            and returns each completed block as a one-cycle fill.
// Revision : 1.0 - initial release
// ============================================================================
module prefetch_issuer #(
    parameter int BLOCK_SIZE_BYTE = 16,
    parameter int QUEUE_DEPTH     = 4,
    parameter int BEAT_BYTES      = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                pf_req_valid,
    input  logic [31-$clog2(BLOCK_SIZE_BYTE):0] pf_req_addr,
    output logic                                pf_req_ready,
    output logic                                mem_req_valid,
    output logic [31:0]                         mem_req_addr,
    input  logic                                mem_req_ready,
    input  logic                                mem_rsp_valid,
    input  logic [31:0]                         mem_rsp_data,
    output logic                                fill_valid,
    output logic [31-$clog2(BLOCK_SIZE_BYTE):0] fill_addr,
    output logic [8*BLOCK_SIZE_BYTE-1:0]        fill_data,
    output logic [15:0]                         drop_cnt
);
    import prefetch_pkg::*;

    localparam int OFS    = $clog2(BLOCK_SIZE_BYTE);
    localparam int BLK_W  = ADDR_W - OFS;
    localparam int BEATS  = BLOCK_SIZE_BYTE / BEAT_BYTES;
    localparam int BEAT_W = cnt_width(BEATS);
    localparam int DATA_W = 8 * BLOCK_SIZE_BYTE;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    issue_state_e       state_q, state_d;
    logic [BLK_W-1:0]   inflight_q, inflight_d;
    logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DATA_W-1:0]  data_buf_q, data_buf_d;
    logic               mem_req_valid_q, mem_req_valid_d;
    logic               fill_valid_q, fill_valid_d;
    logic [BLK_W-1:0]   fill_addr_q, fill_addr_d;
    logic [DATA_W-1:0]  fill_data_q, fill_data_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;

    logic               w_full;
    logic               w_empty;
    logic               w_contains;
    logic [BLK_W-1:0]   w_head;
    logic               w_accept;
    logic               w_dup;
    logic               w_push;
    logic               w_pop;

    pf_req_fifo #(
        .WIDTH (BLK_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (w_push),
        .push_data  (pf_req_addr),
        .pop        (w_pop),
        .pop_data   (w_head),
        .full       (w_full),
        .empty      (w_empty),
        .match_addr (pf_req_addr),
        .contains   (w_contains)
    );

    // Ready depends only on registered queue state, never on this cycle's pop.
    assign pf_req_ready = !w_full;
    assign w_accept     = pf_req_valid && !w_full;
    // The in-flight block counts as pending for every state except IDLE.
    assign w_dup        = w_contains || ((state_q != ST_IDLE) && (pf_req_addr == inflight_q));
    assign w_push       = w_accept && !w_dup;
    assign w_pop        = (state_q == ST_IDLE) && !w_empty;

    assign mem_req_valid = mem_req_valid_q;
    assign mem_req_addr  = {inflight_q, {OFS{1'b0}}};
    assign fill_valid    = fill_valid_q;
    assign fill_addr     = fill_addr_q;
    assign fill_data     = fill_data_q;
    assign drop_cnt      = drop_cnt_q;

    // Issue FSM next-state, beat assembly and saturating duplicate counter.
    always_comb begin
        state_d         = state_q;
        inflight_d      = inflight_q;
        beat_cnt_d      = beat_cnt_q;
        data_buf_d      = data_buf_q;
        mem_req_valid_d = mem_req_valid_q;
        fill_valid_d    = 1'b0;
        fill_addr_d     = fill_addr_q;
        fill_data_d     = fill_data_q;
        drop_cnt_d      = drop_cnt_q;

        if (w_accept && w_dup && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_pop) begin
                    inflight_d      = w_head;
                    mem_req_valid_d = 1'b1;
                    state_d         = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    beat_cnt_d      = '0;
                    state_d         = ST_DATA;
                end
            end
            ST_DATA: begin
                if (mem_rsp_valid) begin
                    data_buf_d[32*beat_cnt_q +: 32] = mem_rsp_data;
                    beat_cnt_d                      = beat_cnt_q + 1'b1;
                    if (beat_cnt_q == LAST_BEAT) begin
                        fill_valid_d = 1'b1;
                        fill_addr_d  = inflight_q;
                        fill_data_d  = data_buf_d;
                        state_d      = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register all FSM state and outputs; reset abandons any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            inflight_q      <= '0;
            beat_cnt_q      <= '0;
            data_buf_q      <= '0;
            mem_req_valid_q <= 1'b0;
            fill_valid_q    <= 1'b0;
            fill_addr_q     <= '0;
            fill_data_q     <= '0;
            drop_cnt_q      <= '0;
        end else begin
            state_q         <= state_d;
            inflight_q      <= inflight_d;
            beat_cnt_q      <= beat_cnt_d;
            data_buf_q      <= data_buf_d;
            mem_req_valid_q <= mem_req_valid_d;
            fill_valid_q    <= fill_valid_d;
            fill_addr_q     <= fill_addr_d;
            fill_data_q     <= fill_data_d;
            drop_cnt_q      <= drop_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_prefetch_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_prefetch_issuer
// Purpose  : Self-checking bench for prefetch_issuer: directed stimulus, a
//            transaction-level reference model compared every cycle, and
//            literal expectations for the key scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prefetch_issuer;

    localparam int DEPTH = 4;
    localparam int BEATS = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         pf_req_valid;
    logic [27:0]  pf_req_addr;
    logic         pf_req_ready;
    logic         mem_req_valid;
    logic [31:0]  mem_req_addr;
    logic         mem_req_ready;
    logic         mem_rsp_valid;
    logic [31:0]  mem_rsp_data;
    logic         fill_valid;
    logic [27:0]  fill_addr;
    logic [127:0] fill_data;
    logic [15:0]  drop_cnt;

    int tests = 0;
    int fails = 0;

    prefetch_issuer #(
        .BLOCK_SIZE_BYTE (16),
        .QUEUE_DEPTH     (DEPTH),
        .BEAT_BYTES      (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pf_req_valid  (pf_req_valid),
        .pf_req_addr   (pf_req_addr),
        .pf_req_ready  (pf_req_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .fill_valid    (fill_valid),
        .fill_addr     (fill_addr),
        .fill_data     (fill_data),
        .drop_cnt      (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // pend holds every address still owed a fill, oldest first; while a
    // transfer is active its block sits at pend[0].
    logic [27:0]  pend[$];
    bit           m_live = 0;
    bit           m_active, m_req_open, m_in_fill;
    int           m_beats;
    logic [31:0]  m_buf[BEATS];
    logic [127:0] m_fill_data;
    logic [15:0]  m_drops;
    int           m_queued;
    bit           m_fire, m_dup;

    always @(posedge clk) begin
        if (rst) begin
            pend.delete();
            m_active   = 0;
            m_req_open = 0;
            m_in_fill  = 0;
            m_beats    = -1;
            m_drops    = 16'd0;
            m_live     = 1;
        end else if (m_live) begin
            m_queued = pend.size() - (m_active ? 1 : 0);
            m_fire   = pf_req_valid && (m_queued < DEPTH);
            m_dup    = 0;
            foreach (pend[i]) if (pend[i] == pf_req_addr) m_dup = 1;

            if (!m_active) begin
                if (pend.size() > 0) begin
                    m_active   = 1;
                    m_req_open = 1;
                end
            end else if (m_req_open) begin
                if (mem_req_ready) begin
                    m_req_open = 0;
                    m_beats    = 0;
                end
            end else if (m_beats >= 0) begin
                if (mem_rsp_valid) begin
                    m_buf[m_beats] = mem_rsp_data;
                    m_beats++;
                    if (m_beats == BEATS) begin
                        m_beats     = -1;
                        m_in_fill   = 1;
                        m_fill_data = {m_buf[3], m_buf[2], m_buf[1], m_buf[0]};
                    end
                end
            end else if (m_in_fill) begin
                m_in_fill = 0;
                m_active  = 0;
                void'(pend.pop_front());
            end

            if (m_fire) begin
                if (m_dup) begin
                    if (m_drops != 16'hFFFF) m_drops++;
                end else begin
                    pend.push_back(pf_req_addr);
                end
            end
        end
    end

    // ---------------- per-cycle compare and fill log ----------------
    logic [27:0]  fills[$];
    logic [127:0] last_fill_data;

    always @(negedge clk) begin
        if (m_live) begin
            check("pf_req_ready", pf_req_ready,
                  ((pend.size() - (m_active ? 1 : 0)) < DEPTH) ? 1'b1 : 1'b0);
            check("mem_req_valid", mem_req_valid, m_req_open);
            if (m_req_open && pend.size() > 0)
                check("mem_req_addr", mem_req_addr, {pend[0], 4'h0});
            check("fill_valid", fill_valid, m_in_fill);
            if (m_in_fill && pend.size() > 0) begin
                check("fill_addr", fill_addr, pend[0]);
                check("fill_data", fill_data, m_fill_data);
            end
            check("drop_cnt", drop_cnt, m_drops);
        end
        if (fill_valid === 1'b1) begin
            fills.push_back(fill_addr);
            last_fill_data = fill_data;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [27:0] a);
        int n = 0;
        while (pf_req_ready !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (pf_req_ready !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL push_timeout: got ready=%b, expected 1", pf_req_ready);
        end
        pf_req_valid = 1'b1;
        pf_req_addr  = a;
        tick();
        pf_req_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (mem_req_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        if (mem_req_valid !== 1'b1) begin
            tests++;
            fails++;
            $display("FAIL req_timeout: got mem_req_valid=%b, expected 1", mem_req_valid);
        end
    endtask

    task automatic handshake();
        wait_req();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = d;
        tick();
        mem_rsp_valid = 1'b0;
    endtask

    task automatic serve_block(input logic [27:0] a);
        handshake();
        for (int i = 0; i < BEATS; i++) beat({a[15:0], 16'(i)});
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int base;
        logic [7:0] pat;

        rst           = 1'b1;
        pf_req_valid  = 1'b0;
        pf_req_addr   = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        repeat (2) tick();
        rst = 1'b0;

        // reset state
        check("rst_mem_req_valid", mem_req_valid, 1'b0);
        check("rst_fill_valid",    fill_valid,    1'b0);
        check("rst_fill_addr",     fill_addr,     28'h0);
        check("rst_fill_data",     fill_data,     128'h0);
        check("rst_drop_cnt",      drop_cnt,      16'h0);
        check("rst_pf_req_ready",  pf_req_ready,  1'b1);

        // 1: single request, two-edge issue latency, one fill pulse
        push(28'h0000123);
        check("t1_no_req_yet", mem_req_valid, 1'b0);
        tick();
        check("t1_req_valid", mem_req_valid, 1'b1);
        check("t1_req_addr",  mem_req_addr,  32'h00001230);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) beat(32'h000000A0 + 32'(i));
        check("t1_fill_valid", fill_valid, 1'b1);
        check("t1_fill_addr",  fill_addr,  28'h0000123);
        check("t1_fill_data",  fill_data,  128'h000000A3_000000A2_000000A1_000000A0);
        tick();
        check("t1_fill_pulse", fill_valid, 1'b0);

        // 2: fill the queue while memory stalls, then drain in order
        base = fills.size();
        for (int i = 0; i < 5; i++) push(28'h10 + 28'(i));
        check("t2_full_ready", pf_req_ready, 1'b0);
        for (int i = 0; i < 5; i++) serve_block(28'h10 + 28'(i));
        repeat (2) tick();
        check("t2_fill_count", 32'(fills.size() - base), 32'd5);
        for (int i = 0; i < 5; i++)
            if (fills.size() > base + i)
                check("t2_fill_order", fills[base + i], 28'h10 + 28'(i));

        // 3: duplicates against the queue and against the in-flight block
        base = fills.size();
        push(28'h20);
        push(28'h20);
        handshake();
        beat(32'h1);
        pf_req_valid = 1'b1;
        pf_req_addr  = 28'h20;
        beat(32'h2);
        pf_req_valid = 1'b0;
        beat(32'h3);
        beat(32'h4);
        repeat (3) tick();
        check("t3_drop_cnt",   drop_cnt, 16'd2);
        check("t3_fill_count", 32'(fills.size() - base), 32'd1);

        // 4: stray beats during REQ, gapped beats during DATA
        push(28'h2A);
        wait_req();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEADBEEF;
        tick();
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        pat  = 8'b1011_0011;   // consumed LSB first: 1,1,0,0,1,1,0,1 -> leading 1 folded below
        base = 0;
        // gap pattern 1,0,0,1,1,0,1
        pat  = 8'b0101_1001;
        for (int i = 0; i < 7; i++) begin
            mem_rsp_valid = pat[i];
            mem_rsp_data  = pat[i] ? (32'h000000B0 + 32'(base)) : 32'hBAD0BAD0;
            if (pat[i]) base++;
            tick();
        end
        mem_rsp_valid = 1'b0;
        check("t4_fill_valid", fill_valid, 1'b1);
        check("t4_fill_addr",  fill_addr,  28'h2A);
        check("t4_fill_data",  fill_data,  128'h000000B3_000000B2_000000B1_000000B0);
        tick();

        // 5: reset in the middle of DATA abandons the transfer
        push(28'h25);
        handshake();
        beat(32'h11);
        beat(32'h22);
        base = fills.size();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_mem_req_valid", mem_req_valid, 1'b0);
        check("t5_mem_req_addr",  mem_req_addr,  32'h0);
        check("t5_fill_valid",    fill_valid,    1'b0);
        check("t5_fill_addr",     fill_addr,     28'h0);
        check("t5_fill_data",     fill_data,     128'h0);
        check("t5_drop_cnt",      drop_cnt,      16'h0);
        check("t5_ready",         pf_req_ready,  1'b1);
        repeat (6) tick();
        check("t5_no_fill", 32'(fills.size() - base), 32'd0);
        push(28'h30);
        serve_block(28'h30);
        check("t5_new_fill_valid", fill_valid, 1'b1);
        check("t5_new_fill_addr",  fill_addr,  28'h30);
        tick();

        // 6: saturating duplicate counter
        push(28'h40);
        wait_req();
        pf_req_valid = 1'b1;
        pf_req_addr  = 28'h40;
        repeat (65535) tick();
        check("t6_drop_max", drop_cnt, 16'hFFFF);
        tick();
        pf_req_valid = 1'b0;
        check("t6_drop_sat", drop_cnt, 16'hFFFF);
        serve_block(28'h40);
        check("t6_fill_addr", fill_addr, 28'h40);
        repeat (3) tick();
        check("t6_drop_final", drop_cnt, 16'hFFFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so a stuck DUT can never hang the run.
    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

endmodule
`default_nettype wire
